// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: read-after-write interlock for the 5-stage pipeline.
// Tracks in-flight writes per GPR with a small saturating counter, bumped when
// an instruction leaves ID and released when WB retires its regfile write.
// id_stall is purely combinational and does not look at id_fire, so the
// ID-to-EXE handshake cannot form a loop through this block.
module gpr_scoreboard #(
  parameter int CNT_W     = 2,
  parameter bit WB_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic        id_rs_ren,
  input  logic [4:0]  id_rt,
  input  logic        id_rt_ren,
  input  logic [4:0]  id_dest,
  input  logic [3:0]  id_gr_we,
  input  logic        id_fire,
  input  logic        ws_valid,
  input  logic [3:0]  ws_gr_we,
  input  logic [4:0]  ws_dest,
  input  logic        flush,
  output logic        id_stall,
  output logic [31:0] busy_mask,
  output logic        sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Entry 0 exists only so indexing by a 5-bit register number is always in
  // range; it is never incremented, so it reads as zero permanently.
  logic [CNT_W-1:0] cnt     [0:31];
  logic [CNT_W-1:0] cnt_nxt [0:31];

  logic             issue;
  logic             retire;
  logic             haz_rs;
  logic             haz_rt;
  logic             sat;
  logic             err_set;
  logic [CNT_W-1:0] cnt_rs;
  logic [CNT_W-1:0] cnt_rt;
  logic [CNT_W-1:0] cnt_dest;
  logic [CNT_W-1:0] cnt_wb;

  // Issue/retire events and the hazard/saturation checks seen by ID.
  always_comb begin
    issue    = id_fire && (|id_gr_we) && (id_dest != 5'd0);
    retire   = ws_valid && (|ws_gr_we) && (ws_dest != 5'd0);
    cnt_rs   = cnt[id_rs];
    cnt_rt   = cnt[id_rt];
    cnt_dest = cnt[id_dest];
    cnt_wb   = cnt[ws_dest];

    haz_rs = id_rs_ren && (id_rs != 5'd0) && (cnt_rs != CNT_ZERO);
    haz_rt = id_rt_ren && (id_rt != 5'd0) && (cnt_rt != CNT_ZERO);
    // With a forwarding regfile, the last outstanding write landing this
    // cycle is as good as already written.
    if (WB_BYPASS) begin
      if (retire && (ws_dest == id_rs) && (cnt_rs == CNT_ONE)) haz_rs = 1'b0;
      if (retire && (ws_dest == id_rt) && (cnt_rt == CNT_ONE)) haz_rt = 1'b0;
    end

    sat = (|id_gr_we) && (id_dest != 5'd0) && (cnt_dest == CNT_MAX) &&
          !(retire && (ws_dest == id_dest));

    id_stall = id_valid && (haz_rs || haz_rt || sat);
  end

  // Next counter values; an issue and retire to the same register cancel out
  // and raise no error even at the counter limits.
  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < 32; r++) begin
      cnt_nxt[r] = cnt[r];
    end
    for (int r = 1; r < 32; r++) begin
      if (issue && (id_dest == 5'(r)) && !(retire && (ws_dest == 5'(r)))) begin
        if (cnt[r] == CNT_MAX) err_set = 1'b1;
        else                   cnt_nxt[r] = cnt[r] + CNT_ONE;
      end
      if (retire && (ws_dest == 5'(r)) && !(issue && (id_dest == 5'(r)))) begin
        if (cnt[r] == CNT_ZERO) err_set = 1'b1;
        else                    cnt_nxt[r] = cnt[r] - CNT_ONE;
      end
    end
  end

  // Counter and sticky-error registers; flush wipes the counters but keeps sb_err.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int r = 0; r < 32; r++) cnt[r] <= CNT_ZERO;
      sb_err <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) cnt[r] <= CNT_ZERO;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= cnt_nxt[r];
      if (err_set) sb_err <= 1'b1;
    end
  end

  // Busy decode straight off the counter registers.
  always_comb begin
    busy_mask = 32'd0;
    for (int r = 1; r < 32; r++) begin
      busy_mask[r] = (cnt[r] != CNT_ZERO);
    end
  end

endmodule
